// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and common widths.
package uart_pkg;

    localparam int BAUD_W = 14;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous input whose idle level is 1.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage further down the chain each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Chain registers reset to the idle (mark) level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, parity/stop checking and a one-entry read buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Rxd,
    input  logic        RxRdEn,
    input  logic [2:0]  DataLenLimit,
    input  logic        StopLenLimit,
    input  logic        ParityEn,
    input  logic        ParityPolarity,
    input  logic [13:0] BaudLimit,
    output logic [7:0]  RxData,
    output logic        RxValid,
    output logic        RxReady,
    output logic        RxParityErr,
    output logic        RxFrameErr,
    output logic        RxOverrun,
    output logic        RxBusy
);

    logic                rxd_s;
    logic                prev_q, prev_d;
    logic                start_edge;
    logic                strobe;
    logic                frame_done;
    logic [DATA_W-1:0]   frame_data;

    uart_rx_state_t      state_q, state_d;
    logic [BAUD_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                accum_q, accum_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;

    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                buf_perr_q, buf_perr_d;
    logic                buf_ferr_q, buf_ferr_d;
    logic                ready_q, ready_d;
    logic                overrun_q, overrun_d;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (Rxd),
        .q   (rxd_s)
    );

    // Start edge detection and the baud counter; a half-period load on the start edge centres all samples.
    always_comb begin
        prev_d     = rxd_s;
        start_edge = (state_q == S_IDLE) && prev_q && !rxd_s;
        strobe     = (cnt_q == '0);
        if (start_edge) begin
            cnt_d = BaudLimit >> 1;
        end else if (strobe) begin
            cnt_d = BaudLimit;
        end else begin
            cnt_d = cnt_q - BAUD_W'(1);
        end
    end

    // Frame FSM: walks start, data, optional parity and stop bits, one step per sample strobe.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        accum_d    = accum_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (strobe) begin
                    if (rxd_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                        accum_d   = ParityPolarity;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (strobe) begin
                    shift_d = {rxd_s, shift_q[DATA_W-1:1]};
                    accum_d = accum_q ^ rxd_s;
                    if (bit_idx_q == DataLenLimit) begin
                        bit_idx_d = '0;
                        state_d   = ParityEn ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (strobe) begin
                    perr_d    = accum_q ^ rxd_s;
                    bit_idx_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (strobe) begin
                    ferr_d = ferr_q | ~rxd_s;
                    if (bit_idx_q == {2'b00, StopLenLimit}) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Receive buffer: accept a finished frame if empty or being popped, otherwise flag an overrun.
    always_comb begin
        frame_data = (DataLenLimit == 3'd7) ? shift_q : {1'b0, shift_q[DATA_W-1:1]};
        data_d     = data_q;
        valid_d    = valid_q;
        buf_perr_d = buf_perr_q;
        buf_ferr_d = buf_ferr_q;
        ready_d    = 1'b0;
        overrun_d  = 1'b0;
        if (frame_done) begin
            if (!valid_q || RxRdEn) begin
                data_d     = frame_data;
                buf_perr_d = perr_d;
                buf_ferr_d = ferr_d;
                valid_d    = 1'b1;
                ready_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (RxRdEn && valid_q) begin
            valid_d    = 1'b0;
            buf_perr_d = 1'b0;
            buf_ferr_d = 1'b0;
        end
    end

    // State registers; reset abandons any frame in progress and empties the buffer.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            accum_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            buf_perr_q <= 1'b0;
            buf_ferr_q <= 1'b0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            accum_q    <= accum_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            buf_perr_q <= buf_perr_d;
            buf_ferr_q <= buf_ferr_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
        end
    end

    assign RxData      = data_q;
    assign RxValid     = valid_q;
    assign RxReady     = ready_q;
    assign RxParityErr = buf_perr_q;
    assign RxFrameErr  = buf_ferr_q;
    assign RxOverrun   = overrun_q;
    assign RxBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames are bit-banged on Rxd with hand-computed expectations.
module tb_uart_rx;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Rxd = 1'b1;
    logic        RxRdEn = 1'b0;
    logic [2:0]  data_len = 3'd7;
    logic        stop_len = 1'b0;
    logic        par_en = 1'b0;
    logic        par_pol = 1'b0;
    logic [13:0] baud = 14'd15;
    logic [7:0]  RxData;
    logic        RxValid, RxReady, RxParityErr, RxFrameErr, RxOverrun, RxBusy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int overrun_cnt = 0;
    int ready_cyc = 0;
    int start_cyc = 0;
    logic [7:0] ready_data = 8'h00;
    logic [7:0] ready_data_prev = 8'h00;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Rxd            (Rxd),
        .RxRdEn         (RxRdEn),
        .DataLenLimit   (data_len),
        .StopLenLimit   (stop_len),
        .ParityEn       (par_en),
        .ParityPolarity (par_pol),
        .BaudLimit      (baud),
        .RxData         (RxData),
        .RxValid        (RxValid),
        .RxReady        (RxReady),
        .RxParityErr    (RxParityErr),
        .RxFrameErr     (RxFrameErr),
        .RxOverrun      (RxOverrun),
        .RxBusy         (RxBusy)
    );

    always #5 Clock = ~Clock;

    // Pulse monitor sampled on the falling edge, away from the active edge.
    always @(negedge Clock) begin
        cyc = cyc + 1;
        if (RxReady === 1'b1) begin
            ready_cnt       = ready_cnt + 1;
            ready_cyc       = cyc;
            ready_data_prev = ready_data;
            ready_data      = RxData;
        end
        if (RxOverrun === 1'b1) begin
            overrun_cnt = overrun_cnt + 1;
        end
    end

    task automatic idle_clocks(input int n);
        Rxd = 1'b1;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic read_pulse();
        RxRdEn = 1'b1;
        @(posedge Clock);
        #1;
        RxRdEn = 1'b0;
    endtask

    // One bit period on Rxd; optionally strobe RxRdEn before the rd_off-th clock edge of the bit.
    task automatic drive_bit(input logic v, input int rd_off);
        Rxd = v;
        for (int i = 0; i <= int'(baud); i++) begin
            if (i == rd_off) RxRdEn = 1'b1;
            @(posedge Clock);
            #1;
            RxRdEn = 1'b0;
        end
    endtask

    // Whole frame using the current configuration; bit index 0 is the start bit.
    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                              input int rd_bit, input int rd_off);
        int ndata;
        int nbits;
        logic v;
        ndata = int'(data_len) + 1;
        nbits = 1 + ndata + int'(par_en) + int'(stop_len) + 1;
        start_cyc = cyc;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0) v = 1'b0;
            else if (b <= ndata) v = data[b-1];
            else if (par_en && b == ndata + 1) v = par_bit;
            else v = stop_bit;
            drive_bit(v, (b == rd_bit) ? rd_off : -1);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        n_cmp++;
        if ({RxValid, RxReady, RxParityErr, RxFrameErr, RxOverrun, RxBusy} !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {RxValid, RxReady, RxParityErr, RxFrameErr, RxOverrun, RxBusy});
        end
        n_cmp++;
        if (RxData !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_data: got %h expected 00", RxData);
        end
        idle_clocks(20);
    endtask

    task automatic test_8n1();
        int r0;
        data_len = 3'd7; stop_len = 1'b0; par_en = 1'b0; par_pol = 1'b0; baud = 14'd15;
        r0 = ready_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
        idle_clocks(4);
        n_cmp++;
        if (ready_cnt - r0 !== 1) begin
            n_err++;
            $display("[TB] FAIL 8n1_ready_count: got %0d expected 1", ready_cnt - r0);
        end
        n_cmp++;
        if (ready_cyc - start_cyc < 148 || ready_cyc - start_cyc > 162) begin
            n_err++;
            $display("[TB] FAIL 8n1_latency: got %0d clocks expected about 152", ready_cyc - start_cyc);
        end
        n_cmp++;
        if ({RxData, RxValid, RxParityErr, RxFrameErr} !== {8'hA5, 3'b100}) begin
            n_err++;
            $display("[TB] FAIL 8n1_buffer: got data=%h v=%b pe=%b fe=%b expected data=a5 v=1 pe=0 fe=0",
                     RxData, RxValid, RxParityErr, RxFrameErr);
        end
        read_pulse();
        n_cmp++;
        if (RxValid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL 8n1_read_clears: got %b expected 0", RxValid);
        end
        idle_clocks(8);
    endtask

    task automatic test_7e2_parity();
        data_len = 3'd6; stop_len = 1'b1; par_en = 1'b1; par_pol = 1'b0;
        // 0x35 has four ones in its low 7 bits, so the even parity bit is 0.
        send_frame(8'h35, 1'b0, 1'b1, -1, -1);
        idle_clocks(4);
        n_cmp++;
        if ({RxData, RxValid, RxParityErr, RxFrameErr} !== {8'h35, 3'b100}) begin
            n_err++;
            $display("[TB] FAIL 7e2_good: got data=%h v=%b pe=%b fe=%b expected data=35 v=1 pe=0 fe=0",
                     RxData, RxValid, RxParityErr, RxFrameErr);
        end
        read_pulse();
        idle_clocks(8);
        send_frame(8'h35, 1'b1, 1'b1, -1, -1);
        idle_clocks(4);
        n_cmp++;
        if ({RxData, RxValid, RxParityErr, RxFrameErr} !== {8'h35, 3'b110}) begin
            n_err++;
            $display("[TB] FAIL 7e2_bad_parity: got data=%h v=%b pe=%b fe=%b expected data=35 v=1 pe=1 fe=0",
                     RxData, RxValid, RxParityErr, RxFrameErr);
        end
        read_pulse();
        n_cmp++;
        if ({RxValid, RxParityErr} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL 7e2_read_clears_perr: got v=%b pe=%b expected 0 0", RxValid, RxParityErr);
        end
        idle_clocks(8);
    endtask

    task automatic test_8o1_frame_err();
        data_len = 3'd7; stop_len = 1'b0; par_en = 1'b1; par_pol = 1'b1;
        // Odd parity: 0x00 needs parity bit 1; stop bit forced low.
        send_frame(8'h00, 1'b1, 1'b0, -1, -1);
        idle_clocks(20);
        n_cmp++;
        if ({RxData, RxValid, RxParityErr, RxFrameErr} !== {8'h00, 3'b101}) begin
            n_err++;
            $display("[TB] FAIL 8o1_frame_err: got data=%h v=%b pe=%b fe=%b expected data=00 v=1 pe=0 fe=1",
                     RxData, RxValid, RxParityErr, RxFrameErr);
        end
        read_pulse();
        n_cmp++;
        if ({RxValid, RxFrameErr} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL 8o1_read_clears_ferr: got v=%b fe=%b expected 0 0", RxValid, RxFrameErr);
        end
        // 0x5A has four ones, so odd parity bit is 1.
        send_frame(8'h5A, 1'b1, 1'b1, -1, -1);
        idle_clocks(4);
        n_cmp++;
        if ({RxData, RxValid, RxParityErr, RxFrameErr} !== {8'h5A, 3'b100}) begin
            n_err++;
            $display("[TB] FAIL 8o1_next_good: got data=%h v=%b pe=%b fe=%b expected data=5a v=1 pe=0 fe=0",
                     RxData, RxValid, RxParityErr, RxFrameErr);
        end
        idle_clocks(8);
    endtask

    task automatic test_glitch();
        int r0;
        int o0;
        r0 = ready_cnt;
        o0 = overrun_cnt;
        Rxd = 1'b0;
        repeat (4) begin
            @(posedge Clock);
            #1;
        end
        Rxd = 1'b1;
        n_cmp++;
        if (RxBusy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL glitch_seen_start: got busy=%b expected 1", RxBusy);
        end
        idle_clocks(30);
        n_cmp++;
        if (RxBusy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL glitch_back_idle: got busy=%b expected 0", RxBusy);
        end
        n_cmp++;
        if ({ready_cnt - r0, overrun_cnt - o0} !== {32'd0, 32'd0}) begin
            n_err++;
            $display("[TB] FAIL glitch_no_pulses: got ready=%0d overrun=%0d expected 0 0",
                     ready_cnt - r0, overrun_cnt - o0);
        end
        n_cmp++;
        if ({RxData, RxValid, RxParityErr, RxFrameErr} !== {8'h5A, 3'b100}) begin
            n_err++;
            $display("[TB] FAIL glitch_buffer_kept: got data=%h v=%b pe=%b fe=%b expected data=5a v=1 pe=0 fe=0",
                     RxData, RxValid, RxParityErr, RxFrameErr);
        end
    endtask

    task automatic test_overrun();
        int o0;
        int r0;
        int rd_off;
        data_len = 3'd7; stop_len = 1'b0; par_en = 1'b0; par_pol = 1'b0;
        read_pulse();
        idle_clocks(4);
        o0 = overrun_cnt;
        send_frame(8'h11, 1'b0, 1'b1, -1, -1);
        idle_clocks(4);
        send_frame(8'h22, 1'b0, 1'b1, -1, -1);
        idle_clocks(4);
        n_cmp++;
        if (overrun_cnt - o0 !== 1) begin
            n_err++;
            $display("[TB] FAIL overrun_count: got %0d expected 1", overrun_cnt - o0);
        end
        n_cmp++;
        if ({RxData, RxValid} !== {8'h11, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL overrun_keeps_old: got data=%h v=%b expected data=11 v=1", RxData, RxValid);
        end
        // The stop-bit sample lands 3 + BaudLimit/2 clocks into the bit: two sync flops plus the edge register.
        o0 = overrun_cnt;
        r0 = ready_cnt;
        rd_off = 3 + int'(baud >> 1);
        send_frame(8'h22, 1'b0, 1'b1, 9, rd_off);
        idle_clocks(4);
        n_cmp++;
        if ({RxData, RxValid} !== {8'h22, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL read_at_done_data: got data=%h v=%b expected data=22 v=1", RxData, RxValid);
        end
        n_cmp++;
        if ({overrun_cnt - o0, ready_cnt - r0} !== {32'd0, 32'd1}) begin
            n_err++;
            $display("[TB] FAIL read_at_done_pulses: got overrun=%0d ready=%0d expected 0 1",
                     overrun_cnt - o0, ready_cnt - r0);
        end
        idle_clocks(8);
    endtask

    task automatic test_reset_mid_frame();
        data_len = 3'd7; stop_len = 1'b0; par_en = 1'b0; par_pol = 1'b0; baud = 14'd15;
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        n_cmp++;
        if (RxBusy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL midframe_busy: got %b expected 1", RxBusy);
        end
        Rxd = 1'b1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        n_cmp++;
        if ({RxBusy, RxValid, RxData} !== {2'b00, 8'h00}) begin
            n_err++;
            $display("[TB] FAIL midframe_reset: got busy=%b v=%b data=%h expected busy=0 v=0 data=00",
                     RxBusy, RxValid, RxData);
        end
        idle_clocks(48);
        send_frame(8'hC3, 1'b0, 1'b1, -1, -1);
        idle_clocks(4);
        n_cmp++;
        if ({RxData, RxValid, RxParityErr, RxFrameErr} !== {8'hC3, 3'b100}) begin
            n_err++;
            $display("[TB] FAIL after_reset_c3: got data=%h v=%b pe=%b fe=%b expected data=c3 v=1 pe=0 fe=0",
                     RxData, RxValid, RxParityErr, RxFrameErr);
        end
        read_pulse();
        idle_clocks(8);
    endtask

    task automatic test_back_to_back();
        int r0;
        int o0;
        baud = 14'd3;
        idle_clocks(8);
        r0 = ready_cnt;
        o0 = overrun_cnt;
        send_frame(8'h96, 1'b0, 1'b1, -1, -1);
        send_frame(8'h69, 1'b0, 1'b1, 3, 0);
        idle_clocks(12);
        n_cmp++;
        if ({ready_cnt - r0, overrun_cnt - o0} !== {32'd2, 32'd0}) begin
            n_err++;
            $display("[TB] FAIL b2b_pulses: got ready=%0d overrun=%0d expected 2 0",
                     ready_cnt - r0, overrun_cnt - o0);
        end
        n_cmp++;
        if ({ready_data_prev, ready_data} !== 16'h9669) begin
            n_err++;
            $display("[TB] FAIL b2b_data: got %h,%h expected 96,69", ready_data_prev, ready_data);
        end
        n_cmp++;
        if ({RxData, RxValid} !== {8'h69, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL b2b_buffer: got data=%h v=%b expected data=69 v=1", RxData, RxValid);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2_parity();
        test_8o1_frame_err();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver with a one-entry receive buffer. It is the peripheral-side counterpart of the UART transmitter and shares its framing configuration: 7/8 data bits, optional even/odd parity, 1/2 stop bits, and a programmable baud divider. It synchronises the asynchronous Rxd pin, samples each bit at mid-bit, checks parity and stop bits, and presents the received byte to the bus interface through a read-strobe handshake.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the Rxd synchroniser (minimum 2).

Ports:
Clock  input  1  system clock; the only clock in the block.
Reset  input  1  synchronous, active-high reset.
Rxd  input  1  serial input pin; asynchronous; idle level is 1.
RxRdEn  input  1  one-cycle strobe that pops the receive buffer.
DataLenLimit  input  3  data bits minus 1 (6 = 7 bits, 7 = 8 bits).
StopLenLimit  input  1  stop bits minus 1 (0 = 1 bit, 1 = 2 bits).
ParityEn  input  1  1 = parity bit present.
ParityPolarity  input  1  0 = even parity, 1 = odd parity.
BaudLimit  input  14  clock frequency / baud rate minus 1; minimum legal value is 3.
RxData  output  8  buffered byte; for 7-bit frames, bit 7 = 0.
RxValid  output  1  buffer full.
RxReady  output  1  one-cycle pulse when a new byte enters the buffer.
RxParityErr  output  1  parity error status of the buffered byte; valid while RxValid = 1.
RxFrameErr  output  1  stop-bit error status of the buffered byte; valid while RxValid = 1.
RxOverrun  output  1  one-cycle pulse when a completed frame is dropped because the buffer is full.
RxBusy  output  1  1 whenever the FSM is not in S_IDLE.

Behaviour:
Reset (synchronous, takes priority over everything, including mid-frame):
- All synchroniser flops and the edge-detect register = 1.
- FSM = S_IDLE.
- RxValid, RxReady, RxParityErr, RxFrameErr, RxOverrun, RxBusy = 0.
- RxData = 0.
- A frame in progress is abandoned.

Synchroniser and start detection:
- Rxd passes through SYNC_STAGES flops to give RxdS.
- A start edge is prev RxdS = 1 and RxdS = 0, and is detected only in S_IDLE.

Baud counter:
- 14-bit down counter. A sample strobe fires when the counter = 0; the counter then reloads BaudLimit.
- On a start edge the counter loads BaudLimit >> 1, so every sample lands at mid-bit.

FSM:
- S_IDLE: on a start edge, go to S_START.
- S_START: on the strobe, if RxdS = 1 it is a false start; return to S_IDLE with no flags and no buffer write. Otherwise go to S_DATA with BitIdx = 0 and the parity accumulator = ParityPolarity.
- S_DATA: on each strobe, ShiftReg <= {RxdS, ShiftReg[7:1]} and accum ^= RxdS. When BitIdx == DataLenLimit, go to S_PARITY if ParityEn = 1, else go to S_STOP with BitIdx = 0. Otherwise increment BitIdx.
- S_PARITY: on the strobe, perr = accum ^ RxdS. Go to S_STOP with BitIdx = 0.
- S_STOP: on each strobe, ferr |= ~RxdS. When BitIdx == StopLenLimit, the frame is complete; return to S_IDLE in the same cycle so the next start edge can be caught from mid-stop-bit. Otherwise increment BitIdx.
- If ParityEn = 0, perr = 0.

Data alignment:
- 8-bit frames store ShiftReg.
- 7-bit frames store {1'b0, ShiftReg[7:1]}.

Buffer, on frame complete:
- Empty, or RxRdEn in the same cycle: write RxData, RxParityErr and RxFrameErr; RxValid = 1; RxReady pulses in the next cycle (registered).
- Full and no RxRdEn: the new frame is discarded, the old contents are kept, and RxOverrun pulses in the next cycle.
- RxRdEn with no completion: RxValid = 0, and RxParityErr and RxFrameErr clear.
- RxRdEn while the buffer is empty: ignored.

Configuration inputs must stay stable while RxBusy = 1.

Decomposition:
- Package uart_pkg holds:
  - uart_rx_state_t enum {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP};
  - BAUD_W = 14;
  - DATA_W = 8.
  The transmitter's state type may move into the same package.
- One natural sub-module: uart_sync, a parameterised multi-flop synchroniser with a reset value of 1.
- The FSM, baud counter, shift register and buffer stay in uart_rx.

Test Plan:
All scenarios use BaudLimit = 15 (16 clocks per bit) unless stated.
1. 8N1, byte 0xA5 → RxReady pulses once, about 9.5 bit-times after the start edge; RxData = 0xA5; RxValid = 1; both error flags = 0. RxRdEn then clears RxValid.
2. 7E2, byte 0x35 with correct parity bit 0 → RxData = 0x35, RxParityErr = 0. Same frame with parity bit 1 → RxParityErr = 1.
3. 8O1, byte 0x00 with a stop bit of 0 → RxFrameErr = 1, RxData = 0x00. The next good frame, 0x5A, is received correctly after a read.
4. Glitch: Rxd low for 4 clocks, then high → FSM returns to S_IDLE; no RxReady, no flags, RxValid unchanged.
5. Two frames 0x11 then 0x22 with no RxRdEn → RxOverrun pulses once and RxData stays 0x11. Repeat with RxRdEn asserted in the completion cycle of 0x22 → RxData = 0x22, RxValid stays 1, no overrun.
6. Reset asserted mid-S_DATA → next cycle RxBusy = 0 and RxValid = 0. A following frame 0xC3 is received correctly. Back-to-back 8N1 frames with no idle gap at BaudLimit = 3 are both received.
